// File: rtl/prod_accum.sv
// Streaming accumulator: sums unsigned product beats into per-vector results and
// presents sum, beat count and a sticky wrap flag on a two-deep result handshake.
module prod_accum #(
    parameter int WIDTH     = 2,
    parameter int ACC_WIDTH = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_prod,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_ovf
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PEND = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    // Saturating beat counter increment.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_WIDTH'(1'b1);
        end
    endfunction

    state_t                 state_r;
    state_t                 state_s;
    logic [ACC_WIDTH-1:0]   acc_r;
    logic [CNT_WIDTH-1:0]   cnt_r;
    logic                   ovf_r;
    logic [ACC_WIDTH-1:0]   res_sum_r;
    logic [CNT_WIDTH-1:0]   res_cnt_r;
    logic                   res_ovf_r;
    logic                   out_valid_r;
    logic                   in_ready_r;

    logic                   acc_fire_s;
    logic                   out_fire_s;
    logic [ACC_WIDTH:0]     sum_ext_s;
    logic [ACC_WIDTH-1:0]   nsum_s;
    logic [CNT_WIDTH-1:0]   ncnt_s;
    logic                   novf_s;
    logic                   work_load_s;
    logic                   work_clear_s;
    logic                   res_from_next_s;
    logic                   res_from_work_s;

    assign acc_fire_s = in_valid & in_ready_r;
    assign out_fire_s = out_valid_r & out_ready;

    // Next working values for an accepted beat; the extra top bit is the carry-out.
    always_comb begin
        sum_ext_s = {1'b0, acc_r} + (ACC_WIDTH + 1)'(in_prod);
        nsum_s    = sum_ext_s[ACC_WIDTH-1:0];
        novf_s    = ovf_r | sum_ext_s[ACC_WIDTH];
        ncnt_s    = sat_inc(cnt_r);
    end

    // Next-state and register-load decisions.
    always_comb begin
        state_s         = state_r;
        work_load_s     = 1'b0;
        work_clear_s    = 1'b0;
        res_from_next_s = 1'b0;
        res_from_work_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (acc_fire_s && in_last) begin
                    res_from_next_s = 1'b1;
                    work_clear_s    = 1'b1;
                    state_s         = ST_PEND;
                end else if (acc_fire_s) begin
                    work_load_s = 1'b1;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_PEND: begin
                if (acc_fire_s && in_last && out_fire_s) begin
                    res_from_next_s = 1'b1;
                    work_clear_s    = 1'b1;
                    state_s         = ST_PEND;
                end else if (acc_fire_s && in_last) begin
                    // Second completed vector parks in the working registers.
                    work_load_s = 1'b1;
                    state_s     = ST_FULL;
                end else if (acc_fire_s) begin
                    work_load_s = 1'b1;
                    state_s     = out_fire_s ? ST_RUN : ST_PEND;
                end else if (out_fire_s) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_PEND;
                end
            end
            ST_FULL: begin
                if (out_fire_s) begin
                    res_from_work_s = 1'b1;
                    work_clear_s    = 1'b1;
                    state_s         = ST_PEND;
                end else begin
                    state_s = ST_FULL;
                end
            end
            default: begin
                work_clear_s = 1'b1;
                state_s      = ST_RUN;
            end
        endcase
    end

    // State register and registered handshake flags derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_RUN;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_s;
            out_valid_r <= (state_s != ST_RUN);
            in_ready_r  <= (state_s != ST_FULL);
        end
    end

    // Working accumulator registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= {ACC_WIDTH{1'b0}};
            cnt_r <= {CNT_WIDTH{1'b0}};
            ovf_r <= 1'b0;
        end else if (work_clear_s) begin
            acc_r <= {ACC_WIDTH{1'b0}};
            cnt_r <= {CNT_WIDTH{1'b0}};
            ovf_r <= 1'b0;
        end else if (work_load_s) begin
            acc_r <= nsum_s;
            cnt_r <= ncnt_s;
            ovf_r <= novf_s;
        end else begin
            acc_r <= acc_r;
            cnt_r <= cnt_r;
            ovf_r <= ovf_r;
        end
    end

    // Result registers, always loaded as a group.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_sum_r <= {ACC_WIDTH{1'b0}};
            res_cnt_r <= {CNT_WIDTH{1'b0}};
            res_ovf_r <= 1'b0;
        end else if (res_from_next_s) begin
            res_sum_r <= nsum_s;
            res_cnt_r <= ncnt_s;
            res_ovf_r <= novf_s;
        end else if (res_from_work_s) begin
            res_sum_r <= acc_r;
            res_cnt_r <= cnt_r;
            res_ovf_r <= ovf_r;
        end else begin
            res_sum_r <= res_sum_r;
            res_cnt_r <= res_cnt_r;
            res_ovf_r <= res_ovf_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_sum   = res_sum_r;
    assign out_count = res_cnt_r;
    assign out_ovf   = res_ovf_r;

endmodule

// File: doc/prod_accum.md
# prod_accum

Streaming accumulator that sits directly downstream of the n-bit integer multiplier and reduces its product stream into a per-vector sum, for dot-product style benchmarks. Consumes one WIDTH-bit product per valid/ready beat, sums beats until a `last` beat, then presents the sum, beat count and overflow flag on a registered output handshake. A second vector may accumulate while the previous result waits. Input stalls only when both result slots are occupied.

## Interface
- `WIDTH`, 2, width of each incoming product; matches the multiplier's output width.
- `ACC_WIDTH`, 8, accumulator and result width; must be >= WIDTH.
- `CNT_WIDTH`, 8, beat-count width.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  product beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_prod`  in  WIDTH  product value, unsigned.
- `in_last`  in  1  marks the final beat of a vector.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  ACC_WIDTH  vector sum, modulo 2^ACC_WIDTH.
- `out_count`  out  CNT_WIDTH  number of beats in the vector, including the last beat.
- `out_ovf`  out  1  sticky flag: the sum wrapped at least once during the vector.

## Operation
- Handshake definitions:
  - Beat accepted (`acc_fire`) = `in_valid & in_ready`.
  - Result accepted (`out_fire`) = `out_valid & out_ready`.
- Working registers: `acc`, `cnt`, `ovf`.
- On every `acc_fire`, compute the next values:
  - `nsum` = `acc` + zero-extended `in_prod`, modulo 2^ACC_WIDTH.
  - `ncnt` = `cnt` + 1, saturating at 2^CNT_WIDTH-1.
  - `novf` = `ovf` | carry-out of the addition.
- Result registers `out_sum`, `out_count` and `out_ovf` are loaded only as a group.
- **RUN** (no result pending; `out_valid`=0, `in_ready`=1):
  - Non-last beat: working registers <= next values.
  - Last beat: result registers <= next values, working registers <= 0, go to PEND.
- **PEND** (`out_valid`=1, `in_ready`=1; the next vector accumulates):
  - Non-last beat: working registers <= next values. If `out_fire` in the same cycle, go to RUN.
  - Last beat with `out_fire`: result registers <= next values, working registers <= 0, stay in PEND.
  - Last beat without `out_fire`: working registers <= next values (final result held in the working registers), go to FULL.
  - `out_fire` with no beat: go to RUN.
- **FULL** (`out_valid`=1, `in_ready`=0):
  - On `out_fire`: result registers <= working registers, working registers <= 0, go to PEND.
- A single-beat vector (`in_last` set on the first beat) is legal and yields `out_count`=1.
- `in_prod` and `in_last` are ignored when there is no `acc_fire`.

## Timing
- Reset values: state RUN; `acc`, `cnt`, `ovf` = 0; `out_valid`=0, `out_sum`=0, `out_count`=0, `out_ovf`=0.
  - `in_ready`=1 in the cycle after reset is sampled.
- Reset asserted in any state, including mid-vector or while FULL, discards all partial and pending results.
- Latency: `out_valid` rises in the cycle after the last beat's `acc_fire`.
- Throughput: one beat per cycle with no bubbles, as long as the consumer drains each result before a second vector completes.
- `in_ready` is a function of state only; it has no combinational path from `in_valid` or `out_ready`.
- `out_*` are registered. They stay stable while `out_valid` is high and `out_ready` is low.
- FULL to PEND: `in_ready` returns high in the cycle after `out_fire`.

## Test plan
- **Reset:** hold `rst` for 2 cycles with `in_valid`=1 -> `out_valid`=0, `out_sum`=0, `in_ready`=1 after release; no beat accepted during reset.
- **Basic vector:** beats 3,2,1,3 (last on the 4th), `out_ready`=1 -> one cycle after the last beat, `out_valid`=1 for one cycle with `out_sum`=9, `out_count`=4, `out_ovf`=0.
- **Overflow** (`ACC_WIDTH`=4): six beats of 3, last on the 6th -> `out_sum`=2, `out_ovf`=1, `out_count`=6. The next vector (1 beat, last) -> `out_ovf`=0.
- **Backpressure** (`out_ready`=0):
  - Vector A: 1, 2(last). Vector B: 3, 3(last) -> after B's last beat, `in_ready`=0 and `out_sum`=3 is held stable.
  - Pulse `out_ready` -> B's result appears: `out_sum`=6, `out_count`=2. `in_ready`=1 on the next cycle.
- **Simultaneous events:** in PEND, `out_fire` and B's last beat in the same cycle -> the next cycle shows B's result, the state stays PEND, and `in_ready` never drops.
- **Reset mid-operation:** assert `rst` while FULL -> both results are lost. A new vector 2(last) -> `out_sum`=2, `out_count`=1.
